// File: rtl/wb_pkg.sv
// Shared types for the J1-to-Wishbone master adapter: read FSM states,
// the request-FIFO entry and the data returned on a bus abort.
package wb_pkg;

    // Request entries are sized to the default bus. Widen these together with
    // the ADR_W/DAT_W parameters of wb_cpu_master.
    localparam int unsigned REQ_ADR_W = 16;
    localparam int unsigned REQ_DAT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [REQ_ADR_W-1:0] adr;
        logic [REQ_DAT_W-1:0] dat;
    } req_t;

    // Value handed back to the CPU when a read is aborted by the ack timeout.
    localparam logic [REQ_DAT_W-1:0] ERR_DATA = '1;

    // Packs one bus request; reads carry zero data.
    function automatic req_t make_req(input logic                 we,
                                      input logic [REQ_ADR_W-1:0] adr,
                                      input logic [REQ_DAT_W-1:0] dat);
        req_t r;
        r.we  = we;
        r.adr = adr;
        r.dat = we ? dat : '0;
        return r;
    endfunction

endpackage

// File: rtl/if_wb.sv
// Classic pipelined Wishbone bundle. Data names are slave-relative: the
// master drives dat_i and reads dat_o.
interface if_wb #(
    parameter int unsigned ADR_W = 16,
    parameter int unsigned DAT_W = 16
);
    logic             clk;
    logic             rst;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_i;
    logic [DAT_W-1:0] dat_o;
    logic             ack;
    logic             stall;

    modport master (
        input  clk, rst, dat_o, ack, stall,
        output cyc, stb, we, adr, dat_i
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, dat_i,
        output dat_o, ack, stall
    );
endinterface

// File: rtl/wb_req_fifo.sv
// Small synchronous FIFO of bus requests. The head entry is presented
// directly from storage; push and pop may happen in the same cycle, also
// when the FIFO is full. flush_i empties it in one cycle.
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic push_i,
    input  req_t push_data_i,
    input  logic pop_i,
    output req_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    req_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry storage.
    // NOTE: storage is deliberately not reset; the empty flag guards every
    // read, so stale contents are never observed on the bus.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_cpu_master.sv
// Wishbone master adapter for the J1 data/IO port. Writes are posted through
// a request FIFO; reads stall the CPU, drain earlier writes first, and every
// bus cycle is bounded by an ack timeout that aborts and flushes the bus.
module wb_cpu_master
    import wb_pkg::*;
#(
    parameter int unsigned ADR_W      = 16,
    parameter int unsigned DAT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    if_wb.master             wb,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [DAT_W-1:0] cpu_dat_w,
    output logic [DAT_W-1:0] cpu_dat_r,
    output logic             cpu_busy,
    output logic             cpu_err,
    input  logic             cpu_err_clr
);

    // The outstanding counter must hold every FIFO entry plus one in flight.
    localparam int unsigned OUT_W = $clog2(FIFO_DEPTH + 2);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_t           state_q;
    logic [DAT_W-1:0] dat_r_q;
    logic             err_q;
    logic [OUT_W-1:0] outst_q;
    logic [TMO_W-1:0] tmo_q;

    req_t head;
    req_t push_data;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic stb;
    logic pop;
    logic ack_cnt;
    logic bus_idle;
    logic tmo_clr;
    logic tmo_hit;
    logic wr_accept;
    logic rd_push;

    // ------------------------------------------------------------------
    // Issue side: the FIFO head is the current strobe.
    // ------------------------------------------------------------------
    assign stb      = ~fifo_empty;
    assign pop      = stb & ~wb.stall;
    // Acks with nothing outstanding (after reset or an abort) are stale.
    assign ack_cnt  = wb.ack & (outst_q != '0);
    assign bus_idle = fifo_empty & (outst_q == '0);

    // The timer only runs while the bus owes us something.
    assign tmo_clr  = wb.ack | ((outst_q == '0) & ~stb);
    assign tmo_hit  = ~tmo_clr & (tmo_q == TMO_W'(TIMEOUT - 1));

    // A write wins over a simultaneous read; a pop frees a slot this cycle.
    assign wr_accept = cpu_wr & (state_q == IDLE) & (~fifo_full | pop) & ~tmo_hit;
    // The read goes out only once every earlier write has been acked.
    assign rd_push   = bus_idle &
                       (((state_q == IDLE) & cpu_rd & ~cpu_wr) | (state_q == DRAIN));
    assign push      = wr_accept | rd_push;

    // Selects the entry pushed this cycle.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        push_data = '0;
        if (wr_accept) begin
            push_data = make_req(1'b1, REQ_ADR_W'(cpu_adr), REQ_DAT_W'(cpu_dat_w));
        end else if (rd_push) begin
            push_data = make_req(1'b0, REQ_ADR_W'(cpu_adr), '0);
        end
    end

    wb_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (wb.clk),
        .rst_i       (wb.rst),
        .flush_i     (tmo_hit),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Count of strobes accepted by the slave but not yet acknowledged.
    always_ff @(posedge wb.clk) begin
        if (wb.rst || tmo_hit) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_q + OUT_W'(pop) - OUT_W'(ack_cnt);
        end
    end

    // Ack timeout: counts cycles the bus is owed a response without one.
    always_ff @(posedge wb.clk) begin
        if (wb.rst || tmo_hit || tmo_clr) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    // Read sequencer with registered read data and the sticky error flag.
    always_ff @(posedge wb.clk) begin
        if (wb.rst) begin
            state_q <= IDLE;
            dat_r_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (tmo_hit) begin
                err_q <= 1'b1;
            end else if (cpu_err_clr) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (cpu_rd && !cpu_wr) begin
                        state_q <= bus_idle ? ISSUE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (tmo_hit) begin
                        dat_r_q <= ERR_DATA[DAT_W-1:0];
                        state_q <= DONE;
                    end else if (bus_idle) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tmo_hit) begin
                        dat_r_q <= ERR_DATA[DAT_W-1:0];
                        state_q <= DONE;
                    end else if (pop) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (tmo_hit) begin
                        dat_r_q <= ERR_DATA[DAT_W-1:0];
                        state_q <= DONE;
                    end else if (wb.ack) begin
                        dat_r_q <= wb.dat_o;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // The CPU sees busy low now; the held request is not re-issued.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb.stb   = stb;
    assign wb.cyc   = stb | (outst_q != '0);
    assign wb.we    = stb & head.we;
    assign wb.adr   = stb ? head.adr[ADR_W-1:0] : '0;
    assign wb.dat_i = stb ? head.dat[DAT_W-1:0] : '0;

    assign cpu_dat_r = dat_r_q;
    assign cpu_err   = err_q;
    assign cpu_busy  = cpu_wr ? ~wr_accept : (cpu_rd & (state_q != DONE));

endmodule

// File: tb/tb_wb_cpu_master.sv
// Self-checking bench for wb_cpu_master: a RAM slave with programmable stall
// and ack suppression, a bus scoreboard fed by the CPU driver, a table of
// single transactions and hand-written multi-cycle sequences.
module tb_wb_cpu_master;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_rd = 1'b0;
    logic          cpu_wr = 1'b0;
    logic          cpu_err_clr = 1'b0;
    logic [AW-1:0] cpu_adr = '0;
    logic [DW-1:0] cpu_dat_w = '0;
    logic [DW-1:0] cpu_dat_r;
    logic          cpu_busy;
    logic          cpu_err;

    if_wb #(.ADR_W(AW), .DAT_W(DW)) wb_if ();
    assign wb_if.clk = clk;
    assign wb_if.rst = rst;

    wb_cpu_master #(
        .ADR_W      (AW),
        .DAT_W      (DW),
        .FIFO_DEPTH (2),
        .TIMEOUT    (255)
    ) dut (
        .wb          (wb_if),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_adr     (cpu_adr),
        .cpu_dat_w   (cpu_dat_w),
        .cpu_dat_r   (cpu_dat_r),
        .cpu_busy    (cpu_busy),
        .cpu_err     (cpu_err),
        .cpu_err_clr (cpu_err_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- RAM slave ----------------
    logic [DW-1:0] ram [64];
    int            stall_n   = 0;
    bit            ack_en    = 1'b1;
    bit            force_ack = 1'b0;
    int            wait_cnt  = 0;
    logic          ack_q     = 1'b0;
    logic [DW-1:0] rdat_q    = '0;

    assign wb_if.stall = wb_if.stb && (wait_cnt < stall_n);
    assign wb_if.ack   = ack_q | force_ack;
    assign wb_if.dat_o = rdat_q;

    always @(posedge clk) begin
        if (wb_if.stb && !wb_if.stall) begin
            wait_cnt <= 0;
            ack_q    <= ack_en;
            if (wb_if.we) ram[wb_if.adr[5:0]] <= wb_if.dat_i;
            rdat_q   <= ram[wb_if.adr[5:0]];
        end else begin
            if (wb_if.stb) wait_cnt <= wait_cnt + 1;
            ack_q <= 1'b0;
        end
    end

    // ---------------- bus monitor / scoreboard ----------------
    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } bus_t;

    bus_t exp_q[$];
    int   cyc_n = 0;
    int   n_rd_stb = 0;
    int   cyc_hi_n = 0;
    int   first_ack_cyc = -1;
    int   rd_stb_cyc = -1;
    logic prev_stalled = 1'b0;
    bus_t prev_bus = '0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        bus_t cur;
        bus_t e;
        cur = '{we: wb_if.we, adr: wb_if.adr, dat: wb_if.dat_i};
        if (wb_if.cyc) cyc_hi_n++;
        if (wb_if.ack && first_ack_cyc < 0) first_ack_cyc = cyc_n;
        if (wb_if.stb && prev_stalled) check("stall_hold", cur, prev_bus);
        if (wb_if.stb && !wb_if.stall) begin
            if (!wb_if.we) begin
                n_rd_stb++;
                rd_stb_cyc = cyc_n;
            end
            check("stb_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bus_we", wb_if.we, e.we);
                check("bus_adr", wb_if.adr, e.adr);
                if (e.we) check("bus_dat", wb_if.dat_i, e.dat);
            end
        end
        prev_stalled = wb_if.stb && wb_if.stall;
        prev_bus     = cur;
    end

    // ---------------- CPU driver ----------------
    // Called at a falling edge; returns at the falling edge after completion
    // with the request dropped. busy_cycles counts cycles with cpu_busy high.
    task automatic cpu_req(input bit we, input bit both, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, output int busy_cycles,
                           output logic [DW-1:0] rdata);
        busy_cycles = 0;
        cpu_wr    = we;
        cpu_rd    = !we || both;
        cpu_adr   = adr;
        cpu_dat_w = dat;
        exp_q.push_back('{we: we, adr: adr, dat: we ? dat : '0});
        #1;
        while (cpu_busy && busy_cycles < 1000) begin
            @(negedge clk);
            #1;
            busy_cycles++;
        end
        if (busy_cycles >= 1000) check("cpu_busy_bound", busy_cycles, 0);
        rdata = cpu_dat_r;
        @(negedge clk);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (wb_if.cyc && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 64'(n < 2000), 1);
    endtask

    // ---------------- single-transaction table ----------------
    typedef struct {
        bit            we;
        bit            both;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            stall;
        int            exp_busy;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            b;
        int            b2;
        int            b3;
        int            start_cyc;
        int            rd_base;
        logic [DW-1:0] rd;

        vecs[0] = '{1'b1, 1'b0, 16'h0044, 16'h5A5A, 0, 0, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0044, 16'h0000, 0, 3, 16'h5A5A};
        vecs[2] = '{1'b1, 1'b0, 16'h0041, 16'hA5A5, 2, 0, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 16'h0041, 16'h0000, 2, 5, 16'hA5A5};
        vecs[4] = '{1'b1, 1'b1, 16'h0042, 16'h7777, 1, 0, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 1, 4, 16'h7777};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cyc", wb_if.cyc, 0);
        check("rst_stb", wb_if.stb, 0);
        check("rst_we", wb_if.we, 0);
        check("rst_adr", wb_if.adr, 0);
        check("rst_dat_i", wb_if.dat_i, 0);
        check("rst_dat_r", cpu_dat_r, 0);
        check("rst_err", cpu_err, 0);
        check("rst_busy", cpu_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Posted write, zero-stall RAM: cycle-accurate bus trace
        cpu_req(1'b1, 1'b0, 16'h0040, 16'h0123, b, rd);
        check("wr_busy", b, 0);
        check("wr_c1_stb", wb_if.stb, 1);
        check("wr_c1_we", wb_if.we, 1);
        check("wr_c1_adr", wb_if.adr, 16'h0040);
        check("wr_c1_dat", wb_if.dat_i, 16'h0123);
        @(negedge clk);
        check("wr_c2_stb", wb_if.stb, 0);
        check("wr_c2_ack", wb_if.ack, 1);
        check("wr_c2_cyc", wb_if.cyc, 1);
        @(negedge clk);
        check("wr_c3_cyc", wb_if.cyc, 0);

        // Read back: busy cycles 0-2, strobe at cycle 1, data at cycle 3
        rd_base   = n_rd_stb;
        start_cyc = cyc_n;
        cpu_req(1'b0, 1'b0, 16'h0040, 16'h0000, b, rd);
        check("rd_busy", b, 3);
        check("rd_data", rd, 16'h0123);
        check("rd_stb_cycle", rd_stb_cyc - start_cyc, 1);
        wait_idle();
        check("rd_one_strobe", n_rd_stb - rd_base, 1);

        // Table of isolated transactions
        foreach (vecs[i]) begin
            stall_n = vecs[i].stall;
            cpu_req(vecs[i].we, vecs[i].both, vecs[i].adr, vecs[i].dat, b, rd);
            check($sformatf("vec%0d_busy", i), b, vecs[i].exp_busy);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            wait_idle();
        end

        // Three back-to-back writes against a slave stalling 3 cycles per beat
        stall_n = 3;
        cpu_req(1'b1, 1'b0, 16'h0000, 16'h0010, b, rd);
        cpu_req(1'b1, 1'b0, 16'h0001, 16'h0011, b2, rd);
        cpu_req(1'b1, 1'b0, 16'h0002, 16'h0012, b3, rd);
        check("b2b_w0_busy", b, 0);
        check("b2b_w1_busy", b2, 0);
        check("b2b_w2_busy", b3, 2);
        wait_idle();
        stall_n = 0;
        check("ram0", ram[0], 16'h0010);
        check("ram1", ram[1], 16'h0011);
        check("ram2", ram[2], 16'h0012);

        // Write immediately followed by a read of the same address
        first_ack_cyc = -1;
        cpu_req(1'b1, 1'b0, 16'h0005, 16'hBEEF, b, rd);
        cpu_req(1'b0, 1'b0, 16'h0005, 16'h0000, b2, rd);
        check("raw_wr_busy", b, 0);
        check("raw_rd_busy", b2, 5);
        check("raw_data", rd, 16'hBEEF);
        check("raw_order", 64'(rd_stb_cyc > first_ack_cyc), 1);
        wait_idle();

        // Read never acked: abort after 255 bus cycles
        ack_en   = 1'b0;
        cyc_hi_n = 0;
        cpu_req(1'b0, 1'b0, 16'h0007, 16'h0000, b, rd);
        check("tmo_busy", b, 256);
        check("tmo_data", rd, 16'hFFFF);
        check("tmo_cyc_len", cyc_hi_n, 255);
        check("tmo_cyc_low", wb_if.cyc, 0);
        check("tmo_err_set", cpu_err, 1);
        cpu_err_clr = 1'b1;
        @(negedge clk);
        cpu_err_clr = 1'b0;
        check("tmo_err_clr", cpu_err, 0);

        // Reset with two writes outstanding, then stale acks
        cpu_req(1'b1, 1'b0, 16'h0020, 16'h1111, b, rd);
        cpu_req(1'b1, 1'b0, 16'h0021, 16'h2222, b, rd);
        @(negedge clk);
        check("pre_rst_cyc", wb_if.cyc, 1);
        check("pre_rst_stb", wb_if.stb, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_cyc", wb_if.cyc, 0);
        check("post_rst_stb", wb_if.stb, 0);
        check("post_rst_busy", cpu_busy, 0);
        rst       = 1'b0;
        ack_en    = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        force_ack = 1'b0;
        check("stale_ack_cyc", wb_if.cyc, 0);
        @(negedge clk);
        check("stale_ack_cyc2", wb_if.cyc, 0);
        cpu_req(1'b1, 1'b0, 16'h0022, 16'h3C3C, b, rd);
        wait_idle();
        cpu_req(1'b0, 1'b0, 16'h0022, 16'h0000, b2, rd);
        check("after_rst_wr_busy", b, 0);
        check("after_rst_rd_busy", b2, 3);
        check("after_rst_data", rd, 16'h3C3C);
        wait_idle();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
